// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline: PC register, next-PC select and IF/ID register.
// Optional FETCH_PERF_EN adds saturating fetch/stall performance counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 6,
  parameter int          LAST_IDX = 20
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rd,
  input  logic              stall_f,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              br_taken,
  input  logic [31:0]       br_target,
  input  logic              j_taken,
  input  logic [31:0]       j_target,
  input  logic              jr_taken,
  input  logic [31:0]       jr_target,
  output logic [31:0]       pc_f,
  output logic [31:0]       instr_d,
  output logic [31:0]       pc_plus4_d,
  output logic              valid_d,
  output logic              done,
`ifdef FETCH_PERF_EN
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_stalls,
`endif
  output logic              misalign
);

  localparam logic [31:0] LAST_U = LAST_IDX;

  logic [31:0] idx_ext;
  logic        in_range;
  logic [31:0] fetched;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic [31:0] raw_target;

  assign imem_addr = pc_f[ADDR_W+1:2];
  assign idx_ext   = 32'(pc_f[ADDR_W+1:2]);
  assign in_range  = (pc_f[31:ADDR_W+2] == '0) && (idx_ext <= LAST_U);
  assign done      = !in_range;
  assign fetched   = in_range ? imem_rd : 32'h0;
  assign pc_plus4  = pc_f + 32'd4;
  assign redirect  = jr_taken || br_taken || j_taken;

  always_comb begin
    raw_target = j_target;
    if (jr_taken)
      raw_target = jr_target;
    else if (br_taken)
      raw_target = br_target;
  end

  // Redirects under stall_f are dropped; the hazard unit re-presents them.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f     <= RESET_PC;
      misalign <= 1'b0;
    end else begin
      misalign <= 1'b0;
      if (!stall_f) begin
        if (redirect) begin
          pc_f     <= {raw_target[31:2], 2'b00};
          misalign <= |raw_target[1:0];
        end else if (in_range) begin
          pc_f <= pc_plus4;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush_d) begin
      instr_d    <= 32'h0;
      pc_plus4_d <= 32'h0;
      valid_d    <= 1'b0;
    end else if (!stall_d) begin
      instr_d    <= fetched;
      pc_plus4_d <= pc_plus4;
      valid_d    <= in_range;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= 32'h0;
      perf_stalls  <= 32'h0;
    end else begin
      if (!flush_d && !stall_d && in_range && (perf_fetched != 32'hFFFF_FFFF))
        perf_fetched <= perf_fetched + 32'd1;
      if (stall_f && (perf_stalls != 32'hFFFF_FFFF))
        perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed table-driven bench for fetch_stage with a behavioural ROM.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  imem_addr;
  logic [31:0] imem_rd;
  logic        stall_f, stall_d, flush_d;
  logic        br_taken, j_taken, jr_taken;
  logic [31:0] br_target, j_target, jr_target;
  logic [31:0] pc_f, instr_d, pc_plus4_d;
  logic        valid_d, done, misalign;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls;
`endif

  logic [31:0] rom [0:63];
  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;
  assign imem_rd = rom[imem_addr];

  fetch_stage #(.RESET_PC(32'h0), .ADDR_W(6), .LAST_IDX(20)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rd(imem_rd),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .br_taken(br_taken), .br_target(br_target),
    .j_taken(j_taken), .j_target(j_target),
    .jr_taken(jr_taken), .jr_target(jr_target),
    .pc_f(pc_f), .instr_d(instr_d), .pc_plus4_d(pc_plus4_d),
    .valid_d(valid_d), .done(done),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls),
`endif
    .misalign(misalign)
  );

  typedef struct {
    logic        sf, sd, fl, br, j, jr;
    logic [31:0] brt, jt, jrt;
    logic [31:0] pc, instr, pc4;
    logic        valid, dn, mis;
  } vec_t;

  vec_t vec [20];

  function automatic logic [31:0] romv(int i);
    if (i == 0) return 32'h2002_000A;
    if (i == 1) return 32'h2003_0003;
    if (i == 2) return 32'h2004_0000;
    if (i <= 20) return 32'h1000_0000 + 32'(i);
    return 32'hDEAD_0000 + 32'(i);
  endfunction

  function automatic vec_t mk(logic sf, logic sd, logic fl,
                              logic br, logic [31:0] brt, logic j, logic [31:0] jt,
                              logic jr, logic [31:0] jrt,
                              logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                              logic valid, logic dn, logic mis);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fl = fl;
    v.br = br; v.brt = brt; v.j = j; v.jt = jt; v.jr = jr; v.jrt = jrt;
    v.pc = pc; v.instr = instr; v.pc4 = pc4; v.valid = valid; v.dn = dn; v.mis = mis;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(logic sf, logic sd, logic fl, logic br, logic [31:0] brt,
                       logic j, logic [31:0] jt, logic jr, logic [31:0] jrt);
    stall_f = sf; stall_d = sd; flush_d = fl;
    br_taken = br; br_target = brt; j_taken = j; j_target = jt;
    jr_taken = jr; jr_target = jrt;
  endtask

  task automatic chk_all(string tag, logic [31:0] pc, logic [31:0] instr, logic [31:0] pc4,
                         logic valid, logic dn, logic mis);
    chk({tag, " pc_f"}, pc_f, pc);
    chk({tag, " imem_addr"}, {26'h0, imem_addr}, {26'h0, pc[7:2]});
    chk({tag, " instr_d"}, instr_d, instr);
    chk({tag, " pc_plus4_d"}, pc_plus4_d, pc4);
    chk({tag, " valid_d"}, {31'h0, valid_d}, {31'h0, valid});
    chk({tag, " done"}, {31'h0, done}, {31'h0, dn});
    chk({tag, " misalign"}, {31'h0, misalign}, {31'h0, mis});
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = romv(i);

    //            sf sd fl br brt      j  jt       jr jrt      pc       instr      pc4      v  dn mis
    vec[0]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h04, romv(0),  32'h04, 1, 0, 0);
    vec[1]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h08, romv(1),  32'h08, 1, 0, 0);
    vec[2]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h0C, romv(2),  32'h0C, 1, 0, 0);
    vec[3]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h10, romv(3),  32'h10, 1, 0, 0);
    vec[4]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h14, romv(4),  32'h14, 1, 0, 0);
    vec[5]  = mk(1, 1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h14, romv(4),  32'h14, 1, 0, 0);
    vec[6]  = mk(1, 1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h14, romv(4),  32'h14, 1, 0, 0);
    vec[7]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h18, romv(5),  32'h18, 1, 0, 0);
    vec[8]  = mk(0, 0, 1, 1, 32'h44, 0, 32'h0,  0, 32'h0,  32'h44, 32'h0,    32'h00, 0, 0, 0);
    vec[9]  = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h48, romv(17), 32'h48, 1, 0, 0);
    vec[10] = mk(0, 0, 0, 1, 32'h10, 0, 32'h0,  1, 32'h50, 32'h50, romv(18), 32'h4C, 1, 0, 0);
    vec[11] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h54, romv(20), 32'h54, 1, 1, 0);
    vec[12] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h54, 32'h0,    32'h58, 0, 1, 0);
    vec[13] = mk(0, 0, 0, 0, 32'h0,  1, 32'h0,  0, 32'h0,  32'h00, 32'h0,    32'h58, 0, 0, 0);
    vec[14] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  1, 32'h52, 32'h50, romv(0),  32'h04, 1, 0, 1);
    vec[15] = mk(0, 0, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h54, romv(20), 32'h54, 1, 1, 0);
    vec[16] = mk(1, 0, 0, 0, 32'h0,  1, 32'h0A, 0, 32'h0,  32'h54, 32'h0,    32'h58, 0, 1, 0);
    vec[17] = mk(0, 1, 1, 0, 32'h0,  1, 32'h0A, 0, 32'h0,  32'h08, 32'h0,    32'h00, 0, 0, 1);
    vec[18] = mk(0, 1, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,  32'h0C, 32'h0,    32'h00, 0, 0, 0);
    vec[19] = mk(0, 0, 0, 1, 32'h20, 1, 32'h30, 0, 32'h0,  32'h20, romv(3),  32'h10, 1, 0, 0);

    reset = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
`ifdef FETCH_PERF_EN
    chk("reset perf_fetched", perf_fetched, 32'h0);
    chk("reset perf_stalls", perf_stalls, 32'h0);
`endif
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive(vec[i].sf, vec[i].sd, vec[i].fl, vec[i].br, vec[i].brt,
            vec[i].j, vec[i].jt, vec[i].jr, vec[i].jrt);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", i), vec[i].pc, vec[i].instr, vec[i].pc4,
              vec[i].valid, vec[i].dn, vec[i].mis);
`ifdef FETCH_PERF_EN
      if (i == 7) begin
        chk("perf_fetched", perf_fetched, 32'd6);
        chk("perf_stalls", perf_stalls, 32'd2);
      end
`endif
    end

    // Jump to an address with nonzero upper bits: out of range, PC parks there.
    drive(0, 0, 0, 0, 32'h0, 1, 32'h100, 0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("hi_jump", 32'h100, romv(8), 32'h24, 1, 1, 0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk_all("hi_park", 32'h100, 32'h0, 32'h104, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("hi_park2 pc_f", pc_f, 32'h100);

    // Synchronous reset mid-run clears everything again.
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_all("rerun_reset", 32'h0, 32'h0, 32'h0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_all("rerun_first", 32'h04, romv(0), 32'h04, 1, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
